// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: serial stuck-at fault campaign sequencer for the
// 64x64 multiplier netlist. One golden pass, then one pass per fault ID.
// Each pass compacts the product stream into a 32-bit MISR, and the
// result is reported over a valid/ready port.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    launch campaign (sampled in IDLE)
//   fid_start, fid_end       fault-ID range [start, end), captured at start
//   busy, done               campaign running / one-cycle end pulse
//   fault_id, fault_en       fault select and MUX enable to the netlist
//   a_op, b_op               registered operands to the netlist
//   f_in                     netlist product
//   res_valid, res_ready     result handshake
//   res_fid, res_detected    fault ID of result, signature != golden
//   res_sig                  faulty-pass signature
//   det_count, undet_count   saturating result counters
// Optional feature: define FCC_COUNTERS_EN to add det_count/undet_count.
module fault_campaign_ctrl #(
    parameter int FID_W   = 16,
    parameter int STEPS   = 256,
    parameter int DUT_LAT = 1,
    parameter int SIG_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [FID_W-1:0] fid_start,
    input  logic [FID_W-1:0] fid_end,
    output logic             busy,
    output logic             done,
    output logic [FID_W-1:0] fault_id,
    output logic             fault_en,
    output logic [63:0]      a_op,
    output logic [63:0]      b_op,
    input  logic [127:0]     f_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FID_W-1:0] res_fid,
    output logic             res_detected,
    output logic [SIG_W-1:0] res_sig
`ifdef FCC_COUNTERS_EN
    ,
    output logic [FID_W-1:0] det_count,
    output logic [FID_W-1:0] undet_count
`endif
);

    localparam int QW    = $clog2(STEPS);
    localparam int CNT_W = QW + 2;

    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(STEPS + DUT_LAT - 1);
    localparam logic [CNT_W-1:0] LAT       = CNT_W'(DUT_LAT);

    localparam logic [63:0]      SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [SIG_W-1:0] POLY = SIG_W'(32'h0040_0007);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOLD_RUN,
        S_GOLD_DRAIN,
        S_FAULT_RUN,
        S_FAULT_DRAIN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] step_n;
    logic [1:0]       quarter_n;
    logic [7:0]       pat_n;
    logic [FID_W-1:0] fid;
    logic [FID_W-1:0] fid_inc;
    logic [FID_W-1:0] fid_last;
    logic             empty;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] gold_sig;
    logic [SIG_W-1:0] misr_n;
    logic [31:0]      fold;
    logic [63:0]      lfsr_n;

    logic load;
    logic accept;
    logic in_run;
    logic in_pass;
    logic in_gold;
    logic in_fault;
    logic run_last;
    logic pass_last;
    logic hs;

    assign in_run   = (state == S_GOLD_RUN) || (state == S_FAULT_RUN);
    assign in_gold  = (state == S_GOLD_RUN) || (state == S_GOLD_DRAIN);
    assign in_fault = (state == S_FAULT_RUN) || (state == S_FAULT_DRAIN);
    assign in_pass  = in_gold || in_fault;

    assign run_last  = (cnt == RUN_LAST);
    assign pass_last = (cnt == PASS_LAST);
    assign accept    = (state == S_IDLE) && start;
    assign hs        = (state == S_REPORT) && res_ready;
    assign fid_inc   = fid + FID_W'(1);

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_REPORT);
    assign fault_en  = in_fault;
    assign fault_id  = (in_fault || state == S_REPORT) ? fid : '0;

    // Fibonacci LFSR, taps 64,63,61,60
    assign lfsr_n = {a_op[62:0], a_op[63] ^ a_op[62] ^ a_op[60] ^ a_op[59]};

    assign fold = f_in[31:0] ^ f_in[63:32] ^ f_in[95:64] ^ f_in[127:96];

    assign misr_n = {sig[SIG_W-2:0], 1'b0}
                  ^ (sig[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(fold);

    // b_op pattern for the step that follows the current one
    assign step_n    = cnt + CNT_W'(1);
    assign quarter_n = 2'(step_n >> (QW - 2));

    always_comb begin
        case (quarter_n)
            2'd0:    pat_n = 8'hAA;
            2'd1:    pat_n = 8'h55;
            2'd2:    pat_n = 8'hFF;
            default: pat_n = 8'h0F;
        endcase
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_GOLD_RUN;
                    load    = 1'b1;
                end
            end
            S_GOLD_RUN, S_GOLD_DRAIN: begin
                // with DUT_LAT=0 the pass ends in RUN and DRAIN is skipped
                if (pass_last) begin
                    if (empty) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FAULT_RUN;
                        load    = 1'b1;
                    end
                end else if (run_last) begin
                    state_n = S_GOLD_DRAIN;
                end
            end
            S_FAULT_RUN, S_FAULT_DRAIN: begin
                if (pass_last) begin
                    state_n = S_REPORT;
                end else if (run_last) begin
                    state_n = S_FAULT_DRAIN;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    if (fid_inc == fid_last) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FAULT_RUN;
                        load    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            a_op         <= '0;
            b_op         <= '0;
            sig          <= '0;
            gold_sig     <= '0;
            fid          <= '0;
            fid_last     <= '0;
            empty        <= 1'b0;
            res_fid      <= '0;
            res_detected <= 1'b0;
            res_sig      <= '0;
        end else begin
            if (accept) begin
                fid      <= fid_start;
                fid_last <= fid_end;
                empty    <= (fid_end <= fid_start);
            end else if (hs) begin
                fid <= fid_inc;
            end

            if (load) begin
                cnt  <= '0;
                a_op <= SEED;
                b_op <= {56'd0, 8'hAA};
                sig  <= '0;
            end else if (in_pass) begin
                cnt <= cnt + CNT_W'(1);
                // operands hold on the last step and through DRAIN
                if (in_run && !run_last) begin
                    a_op <= lfsr_n;
                    b_op <= {56'd0, pat_n};
                end
                // first DUT_LAT cycles of a pass see stale products
                if (cnt >= LAT) begin
                    sig <= misr_n;
                end
            end

            if (in_gold && pass_last) begin
                gold_sig <= misr_n;
            end

            if (in_fault && pass_last) begin
                res_fid      <= fid;
                res_sig      <= misr_n;
                res_detected <= (misr_n != gold_sig);
            end
        end
    end

`ifdef FCC_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_count   <= '0;
            undet_count <= '0;
        end else if (accept) begin
            det_count   <= '0;
            undet_count <= '0;
        end else if (hs) begin
            if (res_detected && det_count != '1) begin
                det_count <= det_count + FID_W'(1);
            end
            if (!res_detected && undet_count != '1) begin
                undet_count <= undet_count + FID_W'(1);
            end
        end
    end
`endif

endmodule
